blinds_ctrl: RTL and testbench
==============================

BLINDS_CTRL -- requirements
Module: blinds_ctrl

Interface
REQ-001 Parameter STEP_CYCLES, default 4, clock cycles the motor needs to travel one position step (legal range 2..255).
REQ-002 clk  input  1  single clock; all state updates on its rising edge.
REQ-003 rst  input  1  reset, synchronous, active-high.
REQ-004 req_valid  input  1  requester presents a target position.
REQ-005 req_pos  input  2  target: 0 closed, 1 quarter, 2 half, 3 fully open.
REQ-006 req_ready  output  1  controller accepts a request this cycle.
REQ-007 stop  input  1  abort current travel.
REQ-008 a  output  1  position select MSB, equal to pos[1].
REQ-009 b  output  1  position select LSB, equal to pos[0].
REQ-010 func  output  4  one-hot position code; func[pos]=1, all other bits 0.
REQ-011 motor_up  output  1  motor drives toward fully open.
REQ-012 motor_down  output  1  motor drives toward closed.
REQ-013 busy  output  1  travel in progress.
REQ-014 done  output  1  one-cycle pulse: target reached.
REQ-015 aborted  output  1  one-cycle pulse: travel ended by stop.

Function
REQ-016 The block SHALL hold a 2-bit registered position pos, a 2-bit target tgt, and a step timer of width clog2(STEP_CYCLES).
REQ-017 States SHALL be IDLE and MOVING; req_ready=1 only in IDLE; busy=1 only in MOVING.
REQ-018 Handshake: a request is accepted on a rising edge where req_valid=1 and req_ready=1; req_pos is sampled into tgt on that edge.
REQ-019 Accepted req_pos equal to pos: stay IDLE, done=1 the following cycle, no motor activity.
REQ-020 Accepted req_pos different from pos: enter MOVING, timer loaded with STEP_CYCLES-1, direction latched up if tgt>pos else down.
REQ-021 In MOVING, motor_up=1 (up) or motor_down=1 (down); never both; both 0 in IDLE.
REQ-022 Timer decrements each MOVING cycle; on the cycle it reads 0, pos increments (up) or decrements (down) and timer reloads STEP_CYCLES-1.
REQ-023 A single step therefore takes exactly STEP_CYCLES cycles; a move of k positions takes k*STEP_CYCLES cycles from acceptance to the pos update that equals tgt.
REQ-024 When the step update makes pos equal tgt, the state SHALL return to IDLE on the same edge and done SHALL be 1 for the next cycle only.
REQ-025 pos SHALL never wrap: no increment from 3, no decrement from 0 (guaranteed by direction rule; implementation SHALL still saturate).
REQ-026 stop=1 in MOVING: return to IDLE on that edge, pos unchanged, aborted=1 next cycle, done not asserted.
REQ-027 stop=1 on the same cycle as a step completion: pos updates first, then IDLE; if the new pos equals tgt, done=1 and aborted=0, else aborted=1.
REQ-028 stop=1 in IDLE SHALL be ignored; stop has priority over req_valid in the same IDLE cycle (request not accepted).
REQ-029 req_valid during MOVING SHALL be ignored (no queuing); requester must hold it until accepted.
REQ-030 a, b, func SHALL be derived combinationally from registered pos only, so they change only on step edges.

Reset
REQ-031 On rst=1 at a clock edge: state IDLE, pos=0, tgt=0, timer=0, done=0, aborted=0.
REQ-032 Output values after reset: a=0, b=0, func=4'b0001, motor_up=0, motor_down=0, busy=0, req_ready=1.
REQ-033 rst mid-travel SHALL abandon the move without done or aborted pulse; rst overrides stop and req_valid.

Structure
REQ-034 Position encodings (POS_CLOSED=0, POS_QUARTER=1, POS_HALF=2, POS_OPEN=3) and the state enum SHALL live in shared package blinds_pkg.
REQ-035 The timer SHALL be a separate sub-module blinds_step_timer (load, enable, zero flag); everything else stays in blinds_ctrl.

Verification (STEP_CYCLES=4)
REQ-036 Reset then idle -> func=0001, a=b=0, req_ready=1, motors off.
REQ-037 Request 3 from pos 0 -> motor_up for 12 cycles, func steps 0010,0100,1000 every 4 cycles, done pulse once, busy drops.
REQ-038 From pos 3 request 1 -> motor_down 8 cycles, final a=0 b=1 func=0010, done pulse.
REQ-039 Request 2 from 0, stop asserted 6 cycles after acceptance -> pos=1, aborted pulse, no done, req_ready=1.
REQ-040 Request equal to current pos -> done next cycle, busy never asserted; req_valid during MOVING -> ignored, tgt unchanged.
REQ-041 rst asserted mid-travel at pos 2 -> next cycle pos=0, func=0001, no done/aborted pulse.

Source files
------------

// File: rtl/blinds_pkg.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : blinds_pkg
// Description : Shared types and helpers for the window-blind controller.
//               Position encodings, FSM state encoding, and small pure
//               functions for stepping a position and making its one-hot
//               code.
// Revision    : 1.0  initial release
// ============================================================================
package blinds_pkg;

    typedef logic [1:0] pos_t;

    localparam pos_t POS_CLOSED  = 2'd0;
    localparam pos_t POS_QUARTER = 2'd1;
    localparam pos_t POS_HALF    = 2'd2;
    localparam pos_t POS_OPEN    = 2'd3;

    typedef enum logic [0:0] {
        ST_IDLE   = 1'b0,
        ST_MOVING = 1'b1
    } state_t;

    // One position step in the given direction, saturating at both ends so
    // the position can never wrap even if the direction were ever wrong.
    function automatic pos_t step_pos(input pos_t p, input logic up);
        pos_t r;
        r = p;
        if (up) begin
            if (p != POS_OPEN) begin
                r = p + 2'd1;
            end
        end else begin
            if (p != POS_CLOSED) begin
                r = p - 2'd1;
            end
        end
        return r;
    endfunction

    function automatic logic [3:0] pos_onehot(input pos_t p);
        return 4'b0001 << p;
    endfunction

endpackage
`default_nettype wire

// File: rtl/blinds_step_timer.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : blinds_step_timer
// Description : Down-counter timing one motor position step.
//               i_load reloads the count with STEP_CYCLES-1, i_en counts
//               down by one (holding at zero), o_zero flags a count of 0.
// Ports       : clk, rst    clock and synchronous active-high reset
//               i_load      reload to STEP_CYCLES-1 (priority over i_en)
//               i_en        decrement enable
//               o_zero      count currently equals zero
// Revision    : 1.0  initial release
// ============================================================================
module blinds_step_timer #(
    parameter int STEP_CYCLES = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic i_load,
    input  logic i_en,
    output logic o_zero
);

    localparam int            CW       = $clog2(STEP_CYCLES);
    localparam logic [CW-1:0] C_RELOAD = CW'(STEP_CYCLES - 1);
    localparam logic [CW-1:0] C_ONE    = CW'(1);

    logic [CW-1:0] r_cnt_q;
    logic [CW-1:0] w_cnt_d;

    always_comb begin
        w_cnt_d = r_cnt_q;
        if (i_load) begin
            w_cnt_d = C_RELOAD;
        end else if (i_en && (r_cnt_q != '0)) begin
            w_cnt_d = r_cnt_q - C_ONE;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_cnt_q <= '0;
        end else begin
            r_cnt_q <= w_cnt_d;
        end
    end

    assign o_zero = (r_cnt_q == '0);

endmodule
`default_nettype wire

// File: rtl/blinds_ctrl.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : blinds_ctrl
// Description : Window-blind position controller. Accepts a target position
//               over a valid/ready handshake, drives the motor one step at a
//               time (STEP_CYCLES clocks per step) until the target is
//               reached, and reports completion or abort with single-cycle
//               pulses.
// Ports       : clk, rst              clock, synchronous active-high reset
//               req_valid/req_ready   target handshake, req_pos = target
//               stop                  abort travel (ignored when idle)
//               a, b, func            position select bits / one-hot code
//               motor_up, motor_down  motor drive (mutually exclusive)
//               busy                  travel in progress
//               done, aborted         completion / abort pulses
// Revision    : 1.0  initial release
// ============================================================================
module blinds_ctrl
    import blinds_pkg::*;
#(
    parameter int STEP_CYCLES = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       req_valid,
    input  logic [1:0] req_pos,
    output logic       req_ready,
    input  logic       stop,
    output logic       a,
    output logic       b,
    output logic [3:0] func,
    output logic       motor_up,
    output logic       motor_down,
    output logic       busy,
    output logic       done,
    output logic       aborted
);

    state_t r_state_q, w_state_d;
    pos_t   r_pos_q,   w_pos_d;
    pos_t   r_tgt_q,   w_tgt_d;
    logic   r_up_q,    w_up_d;
    logic   r_done_q,  w_done_d;
    logic   r_abort_q, w_abort_d;

    logic   w_tmr_load;
    logic   w_tmr_en;
    logic   w_tmr_zero;
    pos_t   w_pos_step;

    blinds_step_timer #(
        .STEP_CYCLES (STEP_CYCLES)
    ) u_step_timer (
        .clk    (clk),
        .rst    (rst),
        .i_load (w_tmr_load),
        .i_en   (w_tmr_en),
        .o_zero (w_tmr_zero)
    );

    assign w_pos_step = step_pos(r_pos_q, r_up_q);

    always_comb begin
        w_state_d  = r_state_q;
        w_pos_d    = r_pos_q;
        w_tgt_d    = r_tgt_q;
        w_up_d     = r_up_q;
        w_done_d   = 1'b0;
        w_abort_d  = 1'b0;
        w_tmr_load = 1'b0;
        w_tmr_en   = 1'b0;

        case (r_state_q)
            ST_IDLE: begin
                // stop wins over a request presented in the same cycle
                if (req_valid && !stop) begin
                    w_tgt_d = req_pos;
                    if (req_pos == r_pos_q) begin
                        w_done_d = 1'b1;
                    end else begin
                        w_state_d  = ST_MOVING;
                        w_tmr_load = 1'b1;
                        w_up_d     = (req_pos > r_pos_q);
                    end
                end
            end

            ST_MOVING: begin
                if (w_tmr_zero) begin
                    // Step completes this edge; it takes effect even when
                    // stop is also asserted, and reaching the target then
                    // counts as done rather than aborted.
                    w_pos_d    = w_pos_step;
                    w_tmr_load = 1'b1;
                    if (w_pos_step == r_tgt_q) begin
                        w_state_d = ST_IDLE;
                        w_done_d  = 1'b1;
                    end else if (stop) begin
                        w_state_d = ST_IDLE;
                        w_abort_d = 1'b1;
                    end
                end else begin
                    w_tmr_en = 1'b1;
                    if (stop) begin
                        w_state_d = ST_IDLE;
                        w_abort_d = 1'b1;
                    end
                end
            end

            default: begin
                w_state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state_q <= ST_IDLE;
            r_pos_q   <= POS_CLOSED;
            r_tgt_q   <= POS_CLOSED;
            r_up_q    <= 1'b0;
            r_done_q  <= 1'b0;
            r_abort_q <= 1'b0;
        end else begin
            r_state_q <= w_state_d;
            r_pos_q   <= w_pos_d;
            r_tgt_q   <= w_tgt_d;
            r_up_q    <= w_up_d;
            r_done_q  <= w_done_d;
            r_abort_q <= w_abort_d;
        end
    end

    assign req_ready  = (r_state_q == ST_IDLE);
    assign busy       = (r_state_q == ST_MOVING);
    assign motor_up   = busy &&  r_up_q;
    assign motor_down = busy && !r_up_q;
    assign a          = r_pos_q[1];
    assign b          = r_pos_q[0];
    assign func       = pos_onehot(r_pos_q);
    assign done       = r_done_q;
    assign aborted    = r_abort_q;

endmodule
`default_nettype wire

// File: tb/tb_blinds_ctrl.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : tb_blinds_ctrl
// Description : Self-checking bench for blinds_ctrl with STEP_CYCLES = 4.
//               A table of moves is applied in sequence; each move pushes
//               its expected done/aborted pulse to a queue which a monitor
//               pops when the pulse appears. Per-cycle motor, busy and
//               position outputs are checked against a step model.
// Revision    : 1.0  initial release
// ============================================================================
module tb_blinds_ctrl;

    localparam int STEP = 4;

    logic       clk = 1'b0;
    logic       rst;
    logic       req_valid;
    logic [1:0] req_pos;
    logic       req_ready;
    logic       stop;
    logic       a;
    logic       b;
    logic [3:0] func;
    logic       motor_up;
    logic       motor_down;
    logic       busy;
    logic       done;
    logic       aborted;

    blinds_ctrl #(
        .STEP_CYCLES (STEP)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .req_valid  (req_valid),
        .req_pos    (req_pos),
        .req_ready  (req_ready),
        .stop       (stop),
        .a          (a),
        .b          (b),
        .func       (func),
        .motor_up   (motor_up),
        .motor_down (motor_down),
        .busy       (busy),
        .done       (done),
        .aborted    (aborted)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_cmp = 0;
    int n_bad = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // ---------------- scoreboard of expected pulses ----------------
    typedef struct {
        bit         is_done;
        logic [1:0] pos;
        int         accept;
        int         lat;
    } exp_t;

    exp_t sb[$];
    exp_t mon_e;

    always @(negedge clk) begin
        if (done === 1'b1 || aborted === 1'b1) begin
            if (sb.size() == 0) begin
                check("unexpected_pulse", {30'd0, done, aborted}, 32'd0);
            end else begin
                mon_e = sb.pop_front();
                check("pulse_kind", {30'd0, done, aborted},
                      mon_e.is_done ? 32'd2 : 32'd1);
                check("pulse_pos", {30'd0, a, b}, {30'd0, mon_e.pos});
                check("pulse_latency", cyc - mon_e.accept, mon_e.lat);
            end
        end
    end

    // ---------------- move table ----------------
    typedef struct {
        logic [1:0] tgt;
        int         stop_after;  // edge offset after acceptance with stop=1, 0 = none
        bit         noise;       // hold req_valid during the move
        logic [1:0] exp_pos;
        bit         exp_done;    // 1 done, 0 aborted
        int         lat;         // cycles from acceptance edge to pulse-producing edge
    } vec_t;

    logic [1:0] mpos;

    task automatic run_move(input vec_t v);
        int         acc;
        int         el;
        int         steps;
        logic [1:0] start;
        logic [1:0] mp;
        bit         up;
        exp_t       e;
        start = mpos;
        up    = (v.tgt > start);

        @(posedge clk); #1;
        req_valid = 1'b1;
        req_pos   = v.tgt;
        acc       = cyc + 1;
        e.is_done = v.exp_done;
        e.pos     = v.exp_pos;
        e.accept  = acc;
        e.lat     = v.lat;
        sb.push_back(e);
        @(posedge clk); #1;
        req_valid = 1'b0;

        for (int g = 0; g < 64; g++) begin
            @(negedge clk);
            el = cyc - acc;
            if (el < v.lat) begin
                steps = el / STEP;
                mp = up ? start + 2'(steps) : start - 2'(steps);
                check("busy_moving", {31'd0, busy}, 32'd1);
                check("ready_moving", {31'd0, req_ready}, 32'd0);
                check("motor_up_moving", {31'd0, motor_up}, {31'd0, up});
                check("motor_down_moving", {31'd0, motor_down}, {31'd0, !up});
                check("func_moving", {28'd0, func}, 32'd1 << mp);
            end else begin
                check("busy_end", {31'd0, busy}, 32'd0);
                check("ready_end", {31'd0, req_ready}, 32'd1);
                check("motors_end", {30'd0, motor_up, motor_down}, 32'd0);
                check("ab_end", {30'd0, a, b}, {30'd0, v.exp_pos});
                check("func_end", {28'd0, func}, 32'd1 << v.exp_pos);
            end
            stop      = (v.stop_after > 0) && (el + 1 == v.stop_after);
            req_valid = v.noise && (el + 1 < v.lat);
            req_pos   = (v.tgt == 2'd3) ? 2'd0 : 2'd3;
            if (el >= v.lat) break;
        end
        stop      = 1'b0;
        req_valid = 1'b0;
        @(posedge clk); #1;
        check("pulse_consumed", sb.size(), 32'd0);
        sb.delete();
        mpos = v.exp_pos;
    endtask

    vec_t vecs[11];

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int acc;
        vecs[0]  = '{tgt: 2'd3, stop_after: 0, noise: 0, exp_pos: 2'd3, exp_done: 1, lat: 12};
        vecs[1]  = '{tgt: 2'd1, stop_after: 0, noise: 0, exp_pos: 2'd1, exp_done: 1, lat: 8};
        vecs[2]  = '{tgt: 2'd1, stop_after: 0, noise: 0, exp_pos: 2'd1, exp_done: 1, lat: 0};
        vecs[3]  = '{tgt: 2'd2, stop_after: 0, noise: 1, exp_pos: 2'd2, exp_done: 1, lat: 4};
        vecs[4]  = '{tgt: 2'd0, stop_after: 0, noise: 0, exp_pos: 2'd0, exp_done: 1, lat: 8};
        vecs[5]  = '{tgt: 2'd2, stop_after: 6, noise: 0, exp_pos: 2'd1, exp_done: 0, lat: 6};
        vecs[6]  = '{tgt: 2'd3, stop_after: 4, noise: 0, exp_pos: 2'd2, exp_done: 0, lat: 4};
        vecs[7]  = '{tgt: 2'd3, stop_after: 4, noise: 0, exp_pos: 2'd3, exp_done: 1, lat: 4};
        vecs[8]  = '{tgt: 2'd0, stop_after: 1, noise: 0, exp_pos: 2'd3, exp_done: 0, lat: 1};
        vecs[9]  = '{tgt: 2'd0, stop_after: 0, noise: 0, exp_pos: 2'd0, exp_done: 1, lat: 12};
        vecs[10] = '{tgt: 2'd0, stop_after: 0, noise: 0, exp_pos: 2'd0, exp_done: 1, lat: 0};

        rst       = 1'b1;
        req_valid = 1'b0;
        req_pos   = 2'd0;
        stop      = 1'b0;
        mpos      = 2'd0;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;

        // reset state
        @(negedge clk);
        check("rst_func", {28'd0, func}, 32'b0001);
        check("rst_ab", {30'd0, a, b}, 32'd0);
        check("rst_ready", {31'd0, req_ready}, 32'd1);
        check("rst_motors", {30'd0, motor_up, motor_down}, 32'd0);
        check("rst_busy", {31'd0, busy}, 32'd0);
        check("rst_pulses", {30'd0, done, aborted}, 32'd0);

        foreach (vecs[i]) run_move(vecs[i]);

        // stop and request together while idle: request must not be taken
        @(posedge clk); #1;
        stop      = 1'b1;
        req_valid = 1'b1;
        req_pos   = 2'd2;
        @(negedge clk);
        check("idle_stop_busy", {31'd0, busy}, 32'd0);
        check("idle_stop_ready", {31'd0, req_ready}, 32'd1);
        @(posedge clk); #1;
        stop      = 1'b0;
        req_valid = 1'b0;
        repeat (4) @(negedge clk);
        check("idle_stop_func", {28'd0, func}, 32'b0001);
        check("idle_stop_motors", {30'd0, motor_up, motor_down}, 32'd0);

        // reset in the middle of a 0 -> 3 move once position 2 is reached
        @(posedge clk); #1;
        req_valid = 1'b1;
        req_pos   = 2'd3;
        acc       = cyc + 1;
        @(posedge clk); #1;
        req_valid = 1'b0;
        for (int g = 0; g < 64; g++) begin
            @(negedge clk);
            if (cyc - acc >= 9) break;
        end
        check("mid_func_pos2", {28'd0, func}, 32'b0100);
        check("mid_busy", {31'd0, busy}, 32'd1);
        rst = 1'b1;
        @(negedge clk);
        check("midrst_func", {28'd0, func}, 32'b0001);
        check("midrst_ab", {30'd0, a, b}, 32'd0);
        check("midrst_busy", {31'd0, busy}, 32'd0);
        check("midrst_motors", {30'd0, motor_up, motor_down}, 32'd0);
        rst = 1'b0;
        repeat (16) @(negedge clk);
        check("midrst_still_closed", {28'd0, func}, 32'b0001);
        check("midrst_ready", {31'd0, req_ready}, 32'd1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
`default_nettype wire
